// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Stall/flush sequencer for the 5-stage MIPS pipeline registers
// (if2id, id2ex, ex2mem, mem2wb).
//
// It detects three conditions:
//   - a load in EX whose destination is read by the instruction in ID
//   - a branch or jump resolved in MEM that redirects the PC
//   - a data-memory access in MEM that has not completed yet
//
// The data-memory wait is tracked by a small FSM with a timeout. A
// saturating counter records how many cycles the PC was held.
//
// Parameters
//   MEM_TIMEOUT  maximum consecutive dmem wait cycles before ERROR (>= 2)
//   CNT_W        width of the stall-cycle performance counter
//
// Ports
//   i_clk, i_reset         clock; synchronous active-high reset
//   i_id_rs, i_id_rt       source register fields of the ID instruction
//   i_id_usesrt            ID instruction reads rt
//   i_ex_memtoreg          EX instruction is a load
//   i_ex_regwriteen        EX instruction writes a register
//   i_ex_writereg          EX destination register
//   i_mem_branch           MEM instruction is a conditional branch
//   i_mem_zero             ALU zero flag of the MEM instruction
//   i_mem_jump             MEM instruction is j/jal
//   i_mem_jumptoreg        MEM instruction is jr/jalr
//   i_dmem_req             MEM stage accesses data memory
//   i_dmem_ready           data memory completes its access this cycle
//   o_pc_stall             hold the PC
//   o_ifid_stall           hold if2id
//   o_ifid_flush           load a bubble into if2id
//   o_idex_stall           hold id2ex
//   o_idex_flush           load a bubble into id2ex
//   o_exmem_stall          hold ex2mem
//   o_exmem_flush          load a bubble into ex2mem
//   o_memwb_bubble         load a bubble into mem2wb
//   o_pc_redirect          take the MEM-stage pcnext as the next PC
//   o_mem_err              sticky flag: a dmem timeout occurred
//   o_stall_cycles         saturating count of cycles with o_pc_stall = 1
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_usesrt,
  input  logic             i_ex_memtoreg,
  input  logic             i_ex_regwriteen,
  input  logic [4:0]       i_ex_writereg,
  input  logic             i_mem_branch,
  input  logic             i_mem_zero,
  input  logic             i_mem_jump,
  input  logic             i_mem_jumptoreg,
  input  logic             i_dmem_req,
  input  logic             i_dmem_ready,
  output logic             o_pc_stall,
  output logic             o_ifid_stall,
  output logic             o_ifid_flush,
  output logic             o_idex_stall,
  output logic             o_idex_flush,
  output logic             o_exmem_stall,
  output logic             o_exmem_flush,
  output logic             o_memwb_bubble,
  output logic             o_pc_redirect,
  output logic             o_mem_err,
  output logic [CNT_W-1:0] o_stall_cycles
);

  // The wait counter has to be able to hold MEM_TIMEOUT itself.
  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] LAST_WAIT = WCW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_ERROR
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WCW-1:0]   r_wait_cnt;
  logic [WCW-1:0]   w_wait_cnt_next;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cycles;

  logic w_redirect;
  logic w_loaduse;
  logic w_freeze;
  logic w_evaluate;

  // A redirect is any taken control transfer that has been resolved in MEM.
  assign w_redirect = i_mem_jump | i_mem_jumptoreg | (i_mem_branch & i_mem_zero);

  // A load-use hazard exists when a load in EX writes a register that the
  // instruction in ID reads. Register $0 is never a real dependency.
  assign w_loaduse = i_ex_memtoreg & i_ex_regwriteen & (i_ex_writereg != 5'd0) &
                     ((i_ex_writereg == i_id_rs) |
                      (i_id_usesrt & (i_ex_writereg == i_id_rt)));

  // Next-state and strobe logic. The FSM state decides whether the pipeline
  // is frozen for a memory wait or may evaluate hazards. A freeze suppresses
  // hazard handling entirely. When the pipeline is not frozen, a redirect
  // takes priority over a load-use stall, because the dependent instruction
  // is being flushed anyway. During reset all three front registers are
  // flushed so the pipeline restarts from bubbles.
  always_comb begin
    o_pc_stall      = 1'b0;
    o_ifid_stall    = 1'b0;
    o_ifid_flush    = 1'b0;
    o_idex_stall    = 1'b0;
    o_idex_flush    = 1'b0;
    o_exmem_stall   = 1'b0;
    o_exmem_flush   = 1'b0;
    o_memwb_bubble  = 1'b0;
    o_pc_redirect   = 1'b0;
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_freeze        = 1'b0;
    w_evaluate      = 1'b0;

    if (i_reset) begin
      o_ifid_flush    = 1'b1;
      o_idex_flush    = 1'b1;
      o_exmem_flush   = 1'b1;
      o_memwb_bubble  = 1'b1;
      w_state_next    = ST_RUN;
      w_wait_cnt_next = '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_dmem_req && !i_dmem_ready) begin
            w_freeze        = 1'b1;
            w_state_next    = ST_MEM_WAIT;
            w_wait_cnt_next = WCW'(1);
          end else begin
            w_evaluate = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (!i_dmem_ready) begin
            w_freeze        = 1'b1;
            w_wait_cnt_next = r_wait_cnt + 1'b1;
            if (r_wait_cnt == LAST_WAIT) begin
              w_state_next = ST_ERROR;
            end
          end else begin
            w_evaluate      = 1'b1;
            w_state_next    = ST_RUN;
            w_wait_cnt_next = '0;
          end
        end
        ST_ERROR: begin
          w_freeze = 1'b1;
        end
        default: begin
          w_state_next    = ST_RUN;
          w_wait_cnt_next = '0;
        end
      endcase
    end

    if (w_freeze) begin
      o_pc_stall     = 1'b1;
      o_ifid_stall   = 1'b1;
      o_idex_stall   = 1'b1;
      o_exmem_stall  = 1'b1;
      o_memwb_bubble = 1'b1;
    end else if (w_evaluate) begin
      if (w_redirect) begin
        o_pc_redirect = 1'b1;
        o_ifid_flush  = 1'b1;
        o_idex_flush  = 1'b1;
        o_exmem_flush = 1'b1;
      end else if (w_loaduse) begin
        o_pc_stall   = 1'b1;
        o_ifid_stall = 1'b1;
        o_idex_flush = 1'b1;
      end
    end
  end

  // State, wait counter, sticky error flag and stall-cycle counter.
  // The error flag is raised on the same edge that enters ERROR. The stall
  // counter stops at all-ones instead of wrapping, so a long error freeze
  // cannot make it read small again.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= ST_RUN;
      r_wait_cnt     <= '0;
      r_mem_err      <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      if (w_state_next == ST_ERROR) begin
        r_mem_err <= 1'b1;
      end
      if (o_pc_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
    end
  end

  assign o_mem_err      = r_mem_err;
  assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed-vector bench for pipe_hazard_ctrl. A behavioural model follows
// the pipeline rules: it counts consecutive frozen cycles, keeps an error
// flag and a saturating stall count. A compare process checks the DUT
// against that model every cycle. The driver also pins selected cycles to
// hand-computed literal values.
// The DUT is built with a short timeout and a narrow counter, so both the
// timeout and the saturation cases are reachable in a few cycles.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  // Strobe vector order:
  // pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
  // exmem_stall, exmem_flush, memwb_bubble, pc_redirect
  localparam logic [8:0] VEC_IDLE     = 9'b000000000;
  localparam logic [8:0] VEC_RESET    = 9'b001010110;
  localparam logic [8:0] VEC_LOADUSE  = 9'b110010000;
  localparam logic [8:0] VEC_REDIRECT = 9'b001010101;
  localparam logic [8:0] VEC_FREEZE   = 9'b110101010;

  logic             clk;
  logic             reset;
  logic [4:0]       idRs;
  logic [4:0]       idRt;
  logic             idUsesRt;
  logic             exMemToReg;
  logic             exRegWriteEn;
  logic [4:0]       exWriteReg;
  logic             memBranch;
  logic             memZero;
  logic             memJump;
  logic             memJumpToReg;
  logic             dmemReq;
  logic             dmemReady;
  logic             pcStall;
  logic             ifidStall;
  logic             ifidFlush;
  logic             idexStall;
  logic             idexFlush;
  logic             exmemStall;
  logic             exmemFlush;
  logic             memwbBubble;
  logic             pcRedirect;
  logic             memErr;
  logic [CNT_W-1:0] stallCycles;
  logic [8:0]       dutVec;

  int checks = 0;
  int errors = 0;

  // Model state. It is only meaningful once a reset cycle has been seen.
  int mFrozen = 0;
  bit mErr    = 1'b0;
  int mCnt    = 0;
  bit mValid  = 1'b0;

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_id_rs        (idRs),
    .i_id_rt        (idRt),
    .i_id_usesrt    (idUsesRt),
    .i_ex_memtoreg  (exMemToReg),
    .i_ex_regwriteen(exRegWriteEn),
    .i_ex_writereg  (exWriteReg),
    .i_mem_branch   (memBranch),
    .i_mem_zero     (memZero),
    .i_mem_jump     (memJump),
    .i_mem_jumptoreg(memJumpToReg),
    .i_dmem_req     (dmemReq),
    .i_dmem_ready   (dmemReady),
    .o_pc_stall     (pcStall),
    .o_ifid_stall   (ifidStall),
    .o_ifid_flush   (ifidFlush),
    .o_idex_stall   (idexStall),
    .o_idex_flush   (idexFlush),
    .o_exmem_stall  (exmemStall),
    .o_exmem_flush  (exmemFlush),
    .o_memwb_bubble (memwbBubble),
    .o_pc_redirect  (pcRedirect),
    .o_mem_err      (memErr),
    .o_stall_cycles (stallCycles)
  );

  assign dutVec = {pcStall, ifidStall, ifidFlush, idexStall, idexFlush,
                   exmemStall, exmemFlush, memwbBubble, pcRedirect};

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it and report it if it does not match.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs on the falling edge. Argument order:
  // reset, id_rs, id_rt, id_usesrt, ex_memtoreg, ex_regwriteen, ex_writereg,
  // mem_branch, mem_zero, mem_jump, mem_jumptoreg, dmem_req, dmem_ready
  task automatic applyStimulus(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                               input logic usesRt, input logic memToReg, input logic regWr,
                               input logic [4:0] wReg, input logic br, input logic zero,
                               input logic jmp, input logic jr, input logic req,
                               input logic rdy);
    @(negedge clk);
    reset        = rst;
    idRs         = rs;
    idRt         = rt;
    idUsesRt     = usesRt;
    exMemToReg   = memToReg;
    exRegWriteEn = regWr;
    exWriteReg   = wReg;
    memBranch    = br;
    memZero      = zero;
    memJump      = jmp;
    memJumpToReg = jr;
    dmemReq      = req;
    dmemReady    = rdy;
  endtask

  task automatic idle();
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic memStall();
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 1, 0);
  endtask

  // Model and compare process. After each falling edge the inputs are
  // stable. The model works out the required strobes from its own record of
  // the wait, and checks the registered outputs against its values from
  // before this cycle. It then advances to the state it expects after the
  // next rising edge.
  always begin : compareProc
    logic [8:0] expVec;
    bit         freeze;
    bit         redirect;
    bit         loadUse;
    @(negedge clk);
    #2;
    expVec   = VEC_IDLE;
    redirect = memJump || memJumpToReg || (memBranch && memZero);
    loadUse  = exMemToReg && exRegWriteEn && (exWriteReg != 0) &&
               ((exWriteReg == idRs) || (idUsesRt && (exWriteReg == idRt)));
    if (reset) begin
      expVec = VEC_RESET;
    end else begin
      if (mErr)
        freeze = 1'b1;
      else if (mFrozen > 0)
        freeze = !dmemReady;
      else
        freeze = dmemReq && !dmemReady;
      if (freeze)
        expVec = VEC_FREEZE;
      else if (redirect)
        expVec = VEC_REDIRECT;
      else if (loadUse)
        expVec = VEC_LOADUSE;
    end

    checkOutput("model strobes", 32'(dutVec), 32'(expVec));
    if (mValid) begin
      checkOutput("model mem_err", 32'(memErr), 32'(mErr));
      checkOutput("model stall_cycles", 32'(stallCycles), 32'(mCnt));
    end

    if (reset) begin
      mFrozen = 0;
      mErr    = 1'b0;
      mCnt    = 0;
      mValid  = 1'b1;
    end else begin
      if (expVec[8] && mCnt < CNT_MAX) mCnt++;
      if (!mErr) begin
        if (freeze) begin
          mFrozen++;
          if (mFrozen >= MEM_TIMEOUT) mErr = 1'b1;
        end else begin
          mFrozen = 0;
        end
      end
    end
  end

  // Directed sequence with hand-computed checkpoints. Each literal check runs
  // 3 time units after the inputs for that cycle are driven.
  initial begin
    reset = 1'b1;
    idRs = '0; idRt = '0; idUsesRt = 0; exMemToReg = 0; exRegWriteEn = 0;
    exWriteReg = '0; memBranch = 0; memZero = 0; memJump = 0; memJumpToReg = 0;
    dmemReq = 0; dmemReady = 0;

    applyStimulus(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0);
    #3 checkOutput("reset strobes", 32'(dutVec), 32'(VEC_RESET));
    applyStimulus(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0);
    idle();
    #3 checkOutput("post-reset strobes", 32'(dutVec), 32'(VEC_IDLE));
    checkOutput("post-reset stall_cycles", 32'(stallCycles), 32'd0);
    checkOutput("post-reset mem_err", 32'(memErr), 32'd0);

    // lw $8 in EX, add $9,$8,$10 in ID
    applyStimulus(0, 5'd8, 5'd10, 1, 1, 1, 5'd8, 0, 0, 0, 0, 0, 0);
    #3 checkOutput("loaduse rs", 32'(dutVec), 32'(VEC_LOADUSE));
    idle();
    #3 checkOutput("loaduse self-clear", 32'(dutVec), 32'(VEC_IDLE));
    checkOutput("loaduse stall_cycles", 32'(stallCycles), 32'd1);

    // Load to $0, and rt match without rt being read
    applyStimulus(0, 5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 0, 0, 0, 0);
    #3 checkOutput("loaduse r0", 32'(dutVec), 32'(VEC_IDLE));
    applyStimulus(0, 5'd3, 5'd9, 0, 1, 1, 5'd9, 0, 0, 0, 0, 0, 0);
    #3 checkOutput("loaduse rt unused", 32'(dutVec), 32'(VEC_IDLE));
    applyStimulus(0, 5'd3, 5'd9, 1, 1, 1, 5'd9, 0, 0, 0, 0, 0, 0);
    #3 checkOutput("loaduse rt used", 32'(dutVec), 32'(VEC_LOADUSE));
    applyStimulus(0, 5'd9, 5'd0, 0, 0, 1, 5'd9, 0, 0, 0, 0, 0, 0);
    #3 checkOutput("non-load writer", 32'(dutVec), 32'(VEC_IDLE));

    // Redirects; the taken branch beats a simultaneous load-use
    applyStimulus(0, 5'd8, 5'd0, 0, 1, 1, 5'd8, 1, 1, 0, 0, 0, 0);
    #3 checkOutput("branch over loaduse", 32'(dutVec), 32'(VEC_REDIRECT));
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 0, 0, 0);
    #3 checkOutput("branch not taken", 32'(dutVec), 32'(VEC_IDLE));
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0, 0, 1);
    #3 checkOutput("jump", 32'(dutVec), 32'(VEC_REDIRECT));
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0);
    #3 checkOutput("jr", 32'(dutVec), 32'(VEC_REDIRECT));
    idle();
    #3 checkOutput("stall_cycles after loaduses", 32'(stallCycles), 32'd2);

    // Memory wait of 3 cycles; a jump is taken on the release cycle
    for (int i = 0; i < 3; i++) begin
      memStall();
      #3 checkOutput("memwait freeze", 32'(dutVec), 32'(VEC_FREEZE));
    end
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0, 1, 1);
    #3 checkOutput("memwait release redirect", 32'(dutVec), 32'(VEC_REDIRECT));
    idle();
    #3 checkOutput("stall_cycles after wait", 32'(stallCycles), 32'd5);
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 1, 1);
    #3 checkOutput("single-cycle memory", 32'(dutVec), 32'(VEC_IDLE));

    // Ready arrives on the last cycle before the timeout
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) memStall();
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 1, 1);
    #3 checkOutput("ready on timeout cycle", 32'(dutVec), 32'(VEC_IDLE));
    idle();
    #3 checkOutput("back in run", 32'(dutVec), 32'(VEC_IDLE));
    checkOutput("no error on late ready", 32'(memErr), 32'd0);
    checkOutput("stall_cycles before timeout", 32'(stallCycles), 32'd8);

    // Timeout: the error freeze ignores ready and redirects
    for (int i = 0; i < MEM_TIMEOUT; i++) memStall();
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0, 1, 1);
    #3 checkOutput("error freeze", 32'(dutVec), 32'(VEC_FREEZE));
    checkOutput("error mem_err", 32'(memErr), 32'd1);
    for (int i = 0; i < 6; i++) idle();
    #3 checkOutput("error still frozen", 32'(dutVec), 32'(VEC_FREEZE));
    checkOutput("stall_cycles saturated", 32'(stallCycles), 32'(CNT_MAX));
    checkOutput("mem_err sticky", 32'(memErr), 32'd1);

    applyStimulus(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 1, 0);
    #3 checkOutput("reset from error", 32'(dutVec), 32'(VEC_RESET));
    idle();
    #3 checkOutput("after error reset", 32'(dutVec), 32'(VEC_IDLE));
    checkOutput("mem_err cleared", 32'(memErr), 32'd0);
    checkOutput("stall_cycles cleared", 32'(stallCycles), 32'd0);

    // Reset in the middle of a wait aborts it
    memStall();
    memStall();
    applyStimulus(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 1, 0);
    #3 checkOutput("reset mid-wait", 32'(dutVec), 32'(VEC_RESET));
    idle();
    #3 checkOutput("wait aborted", 32'(dutVec), 32'(VEC_IDLE));
    checkOutput("counter after abort", 32'(stallCycles), 32'd0);

    idle();
    idle();
    @(negedge clk);
    #4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
